// File: rtl/cpu_program_loader.sv
// -----------------------------------------------------------------------------
// cpu_program_loader
//
// Receives a byte-serial program image and writes it into the cpu's
// instruction memory. The cpu is held in reset while a frame is loading and is
// released only after a frame whose checksum matches.
//
// Frame layout: A5, LEN_LO, LEN_HI, N x (word low byte, word high byte),
// checksum. The checksum is the XOR of the word bytes only.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : asynchronous reset, active low
//   in_valid         : a byte is offered on in_data
//   in_data          : loader stream byte
//   in_ready         : byte is accepted (1 whenever out of reset)
//   mem_write_enable : one-cycle instruction memory write strobe
//   mem_write_addr   : instruction word address (held between writes)
//   mem_write_data   : instruction word (held between writes)
//   cpu_rst          : active-high reset to the cpu
//   loaded           : last frame completed with a good checksum
//   error            : last frame was rejected (bad length or checksum)
// -----------------------------------------------------------------------------
module cpu_program_loader #(
   parameter int INSTRUCTION_WIDTH    = 16,
   parameter int INSTRUCTION_MEM_SIZE = 1024,
   parameter int ADDR_WIDTH           = $clog2(INSTRUCTION_MEM_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [7:0]                   in_data,
   output logic                         in_ready,
   output logic                         mem_write_enable,
   output logic [ADDR_WIDTH-1:0]        mem_write_addr,
   output logic [INSTRUCTION_WIDTH-1:0] mem_write_data,
   output logic                         cpu_rst,
   output logic                         loaded,
   output logic                         error
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RUN, ERROR
   } state_t;

   localparam logic [7:0]  SYNC_BYTE = 8'hA5;
   // One extra bit so the counter can reach INSTRUCTION_MEM_SIZE without wrapping.
   localparam int          CNT_W     = ADDR_WIDTH + 1;
   localparam logic [16:0] MEM_SIZE  = 17'(INSTRUCTION_MEM_SIZE);

   state_t                 state_q, state_d;
   logic [15:0]            frame_len_q, frame_len_d;
   logic [7:0]             len_lo_q, len_lo_d;
   logic [7:0]             data_lo_q, data_lo_d;
   logic [CNT_W-1:0]       word_cnt_q, word_cnt_d;
   logic [7:0]             csum_q, csum_d;
   logic                   cpu_rst_d, loaded_d, error_d, we_d;
   logic [ADDR_WIDTH-1:0]  addr_d;
   logic [INSTRUCTION_WIDTH-1:0] data_d;

   logic                   accept;
   logic                   sync_seen;
   logic [15:0]            len_full;
   logic                   len_bad;
   logic                   last_word;

   assign in_ready  = rst;
   assign accept    = in_valid && in_ready;
   assign sync_seen = accept && (in_data == SYNC_BYTE);
   assign len_full  = {in_data, len_lo_q};
   assign len_bad   = (len_full == '0) || ({1'b0, len_full} > MEM_SIZE);
   assign last_word = (16'(word_cnt_q) + 16'd1) == frame_len_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register
         // samples pre-edge values regardless of statement order.
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned
      // (which would infer a latch).
      state_d = state_q;
      case (state_q)
         IDLE, RUN, ERROR: if (sync_seen) state_d = LEN_LO;
         LEN_LO:           if (accept) state_d = LEN_HI;
         LEN_HI:           if (accept) state_d = len_bad ? ERROR : DATA_LO;
         DATA_LO:          if (accept) state_d = DATA_HI;
         DATA_HI:          if (accept) state_d = last_word ? CHECK : DATA_LO;
         CHECK:            if (accept) state_d = (csum_q == in_data) ? RUN : ERROR;
         default:          state_d = IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      frame_len_d = frame_len_q;
      len_lo_d    = len_lo_q;
      data_lo_d   = data_lo_q;
      word_cnt_d  = word_cnt_q;
      csum_d      = csum_q;
      cpu_rst_d   = cpu_rst;
      loaded_d    = loaded;
      error_d     = error;
      we_d        = 1'b0;
      addr_d      = mem_write_addr;
      data_d      = mem_write_data;
      case (state_q)
         IDLE, RUN, ERROR: begin
            if (sync_seen) begin
               cpu_rst_d  = 1'b1;
               loaded_d   = 1'b0;
               error_d    = 1'b0;
               word_cnt_d = '0;
               csum_d     = '0;
            end
         end
         LEN_LO: if (accept) len_lo_d = in_data;
         LEN_HI: begin
            if (accept) begin
               frame_len_d = len_full;
               if (len_bad) begin
                  error_d   = 1'b1;
                  cpu_rst_d = 1'b1;
               end
            end
         end
         DATA_LO: begin
            if (accept) begin
               data_lo_d = in_data;
               csum_d    = csum_q ^ in_data;
            end
         end
         DATA_HI: begin
            if (accept) begin
               csum_d     = csum_q ^ in_data;
               we_d       = 1'b1;
               addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
               data_d     = INSTRUCTION_WIDTH'({in_data, data_lo_q});
               // Bounded by frame_len <= INSTRUCTION_MEM_SIZE, so it cannot wrap.
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end
         CHECK: begin
            if (accept) begin
               if (csum_q == in_data) begin
                  cpu_rst_d = 1'b0;
                  loaded_d  = 1'b1;
               end else begin
                  error_d   = 1'b1;
                  cpu_rst_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_len_q      <= '0;
         len_lo_q         <= '0;
         data_lo_q        <= '0;
         word_cnt_q       <= '0;
         csum_q           <= '0;
         cpu_rst          <= 1'b1;
         loaded           <= 1'b0;
         error            <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_write_addr   <= '0;
         mem_write_data   <= '0;
      end else begin
         frame_len_q      <= frame_len_d;
         len_lo_q         <= len_lo_d;
         data_lo_q        <= data_lo_d;
         word_cnt_q       <= word_cnt_d;
         csum_q           <= csum_d;
         cpu_rst          <= cpu_rst_d;
         loaded           <= loaded_d;
         error            <= error_d;
         mem_write_enable <= we_d;
         mem_write_addr   <= addr_d;
         mem_write_data   <= data_d;
      end
   end

endmodule

// File: doc/cpu_program_loader.md
CPU_PROGRAM_LOADER -- requirements
Module: cpu_program_loader

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, meaning instruction word width; only 16 is supported.
REQ-002 SHALL have parameter INSTRUCTION_MEM_SIZE, default 1024, meaning the instruction memory depth in words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(INSTRUCTION_MEM_SIZE), meaning the write address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a byte is offered on in_data.
REQ-007 SHALL have port in_data, input, 8 bits: the loader stream byte.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader accepts the byte.
REQ-009 SHALL have port mem_write_enable, output, 1 bit: the instruction memory write strobe.
REQ-010 SHALL have port mem_write_addr, output, ADDR_WIDTH bits: the instruction memory word address.
REQ-011 SHALL have port mem_write_data, output, INSTRUCTION_WIDTH bits: the instruction word.
REQ-012 SHALL have port cpu_rst, output, 1 bit: active-high reset driven to the cpu.
REQ-013 SHALL have port loaded, output, 1 bit: the last frame completed with a good checksum.
REQ-014 SHALL have port error, output, 1 bit: the last frame was rejected.

Function
REQ-015 SHALL accept a byte on each rising edge where in_valid && in_ready; in_ready SHALL be constant 1 outside reset, and in_valid gaps of any length SHALL be tolerated in every state.
REQ-016 SHALL parse the frame as follows, in order:
- sync byte 0xA5
- LEN_LO, LEN_HI: N instruction words, little-endian 16 bit
- N words, each sent low byte then high byte
- one checksum byte equal to the XOR of all word bytes (length and sync bytes excluded)
REQ-017 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECK, RUN, ERROR.
REQ-018 SHALL, in IDLE, RUN or ERROR, discard every accepted byte other than 0xA5.
REQ-019 SHALL, on an accepted 0xA5 in IDLE, RUN or ERROR, enter LEN_LO and on that same edge set cpu_rst=1, loaded=0, error=0, word counter=0 and checksum accumulator=0.
REQ-020 SHALL, on LEN_HI acceptance, go to ERROR if N==0 or N>INSTRUCTION_MEM_SIZE, and otherwise go to DATA_LO.
REQ-021 SHALL, on each DATA_HI acceptance, register a write on that edge: mem_write_enable=1 for exactly one cycle, mem_write_addr=word counter, mem_write_data={high byte, low byte}; the counter then increments.
REQ-022 SHALL go from DATA_HI to CHECK after word N-1, and otherwise to DATA_LO.
REQ-023 SHALL, on CHECK acceptance with a matching checksum, go to RUN and register cpu_rst=0 and loaded=1 on that edge.
REQ-024 SHALL, on CHECK acceptance with a mismatching checksum, go to ERROR with error=1 and cpu_rst=1; words already written SHALL stay written.
REQ-025 SHALL, on entering ERROR from LEN_HI, set error=1 and cpu_rst=1, and SHALL issue no writes.
REQ-026 SHALL hold mem_write_addr and mem_write_data at their last values while mem_write_enable=0.
REQ-027 SHALL never write an address >= INSTRUCTION_MEM_SIZE, and the word counter SHALL never wrap.
REQ-028 SHALL update the checksum accumulator only on DATA_LO and DATA_HI acceptances.

Reset
REQ-029 SHALL, while rst=0 (immediately and asynchronously), force:
- state=IDLE, cpu_rst=1, loaded=0, error=0
- mem_write_enable=0, mem_write_addr=0, mem_write_data=0
- word counter=0, checksum accumulator=0
REQ-030 SHALL drive in_ready=0 while rst=0.
REQ-031 SHALL treat reset asserted mid-frame as abandoning the frame; the next frame starts at address 0.

Verification
REQ-032 Release reset -> cpu_rst=1, loaded=0, error=0, mem_write_enable=0, in_ready=1.
REQ-033 Send bytes 00 FF 5A, then A5 02 00 34 12 78 56 08 -> only two writes occur: addr 0 = 0x1234 and addr 1 = 0x5678, each a one-cycle strobe; cpu_rst=0 and loaded=1 on the edge accepting 0x08.
REQ-034 Send the same frame with checksum 09 -> both writes still occur, then error=1, cpu_rst=1, loaded=0; a following good frame clears error and releases cpu_rst.
REQ-035 Send A5 01 04 (N=1025), and separately A5 00 00 -> error=1 on LEN_HI acceptance, no mem_write_enable pulse.
REQ-036 Assert rst=0 mid-way after A5 02 00 34 -> outputs reset immediately; a following good frame writes from addr 0.
REQ-037 Insert random in_valid=0 gaps in the REQ-033 frame, then send A5 while in RUN -> same writes as REQ-033; the A5 in RUN reasserts cpu_rst=1 and clears loaded on its acceptance edge.
